// File: rtl/iob_2p_mem_tiled_pipe.sv
// rtl/iob_2p_mem_tiled_pipe.sv - two-port tiled RAM with byte strobes, read-valid, range check and clear-after-reset
// Optional IOB_2P_MEM_TILED_FWD_EN: forward same-cycle same-address write data to the read response.
module iob_2p_mem_tiled_pipe #(
  parameter int DATA_W      = 16,
  parameter int N_WORDS     = 8000,
  parameter int TILE_ADDR_W = 12,
  parameter int USE_RAM     = 1,
  parameter int ADDR_W      = $clog2(N_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [ADDR_W-1:0]     w_addr,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [DATA_W/8-1:0]   w_strb,
  input  logic                  r_en,
  input  logic [ADDR_W-1:0]     r_addr,
  output logic [DATA_W-1:0]     r_data,
  output logic                  r_valid,
  output logic                  init_busy
);

  localparam int TILE_WORDS = 1 << TILE_ADDR_W;
  localparam int N_TILES    = (N_WORDS + TILE_WORDS - 1) / TILE_WORDS;
  localparam int TILE_W     = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam int INIT_LEN   = (TILE_WORDS < N_WORDS) ? TILE_WORDS : N_WORDS;
  localparam int N_BYTES    = DATA_W / 8;
  localparam int CNT_W      = TILE_ADDR_W + 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(N_WORDS);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rvalid_q, rin_q, busy;
  logic [TILE_W-1:0]      tile_q;
  logic [DATA_W-1:0]      hold_q, r_data_d, rd_word;
  logic [TILE_W-1:0]      w_tile, r_tile;
  logic [TILE_ADDR_W-1:0] w_local, r_local;
  logic                   w_in, r_in, w_ok, r_ok;
  logic [DATA_W-1:0]      tile_rdata [N_TILES];

  assign busy      = (state_q == ST_INIT);
  assign init_busy = busy;
  assign w_tile    = TILE_W'(w_addr >> TILE_ADDR_W);
  assign r_tile    = TILE_W'(r_addr >> TILE_ADDR_W);
  assign w_local   = TILE_ADDR_W'(w_addr);
  assign r_local   = TILE_ADDR_W'(r_addr);
  assign w_in      = ({1'b0, w_addr} < LIMIT);
  assign r_in      = ({1'b0, r_addr} < LIMIT);
  assign w_ok      = w_en && !busy && w_in;
  assign r_ok      = r_en && !busy && r_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(INIT_LEN - 1)) state_d = ST_RUN;
    end
  end

  for (genvar t = 0; t < N_TILES; t++) begin : g_tile
    // The last tile may be partial; clearing stops at its real size.
    localparam int SIZE = (t == N_TILES - 1) ? (N_WORDS - t * TILE_WORDS) : TILE_WORDS;
    logic [DATA_W-1:0] mem [TILE_WORDS];
    logic [DATA_W-1:0] rdata_q;
    logic              clr, wr_sel, rd_sel;

    assign clr    = busy && (cnt_q < CNT_W'(SIZE));
    assign wr_sel = w_ok && (w_tile == TILE_W'(t));
    assign rd_sel = r_ok && (r_tile == TILE_W'(t));

    always_ff @(posedge clk) begin
      if (clr) begin
        mem[cnt_q[TILE_ADDR_W-1:0]] <= '0;
      end else if (wr_sel) begin
        for (int b = 0; b < N_BYTES; b++) begin
          if (w_strb[b]) mem[w_local][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
      if (rd_sel) rdata_q <= mem[r_local];
    end

    assign tile_rdata[t] = rdata_q;
  end

`ifdef IOB_2P_MEM_TILED_FWD_EN
  logic                fwd_q;
  logic [DATA_W-1:0]   fwd_data_q;
  logic [N_BYTES-1:0]  fwd_strb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      fwd_strb_q <= '0;
    end else begin
      fwd_q      <= w_ok && r_ok && (w_addr == r_addr);
      fwd_data_q <= w_data;
      fwd_strb_q <= w_strb;
    end
  end
`endif

  always_comb begin
    rd_word = tile_rdata[tile_q];
`ifdef IOB_2P_MEM_TILED_FWD_EN
    for (int b = 0; b < N_BYTES; b++) begin
      if (fwd_q && fwd_strb_q[b]) rd_word[8*b +: 8] = fwd_data_q[8*b +: 8];
    end
`endif
    if (rvalid_q)          r_data_d = rin_q ? rd_word : '0;
    else if (USE_RAM != 0) r_data_d = '0;
    else                   r_data_d = hold_q;
  end

  assign r_data  = r_data_d;
  assign r_valid = rvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rin_q    <= 1'b0;
      tile_q   <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= r_en && !busy;
      rin_q    <= r_in;
      tile_q   <= r_tile;
      hold_q   <= r_data_d;
    end
  end

endmodule
